// File: rtl/sync_pkg.sv
// Shared definitions for the clk_b-side consumers of toggle_sync: FSM state
// encoding, a saturating increment and the window-counter width rule.
package sync_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_COUNT = 1'b1
  } state_t;

  // Width of a counter that has to reach window-1 (window >= 2).
  function automatic int win_cnt_w(input int window);
    return $clog2(window);
  endfunction

  // Add one when inc is set, but never step past max_value.
  // Callers zero-extend narrower operands to 32 bits and slice the result.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value,
                                          input logic        inc);
    logic [31:0] result;
    if (inc && (value < max_value)) begin
      result = value + 32'd1;
    end else begin
      result = value;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_edge_qual.sv
// Turns the synchronised sig_b into a per-cycle event strobe: either the level
// itself or only its rising edge. The history register runs every cycle so that
// a consumer switching on while sig_b is already high sees no false edge.
module sync_edge_qual #(
  parameter int EDGE_MODE = 0
) (
  input  logic clk_b,
  input  logic rst_n,
  input  logic sig_b,
  output logic evt
);

  logic sig_b_q_r;

  // Previous-cycle copy of sig_b, captured unconditionally.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      sig_b_q_r <= 1'b0;
    end else begin
      sig_b_q_r <= sig_b;
    end
  end

  // Event qualification: level or rising edge.
  always_comb begin
    evt = 1'b0;
    if (EDGE_MODE != 0) begin
      evt = sig_b & ~sig_b_q_r;
    end else begin
      evt = sig_b;
    end
  end

endmodule

// File: rtl/sync_event_counter.sv
// Counts sig_b events over fixed windows of WINDOW clk_b cycles and offers
// each window's (saturating) count to a reader over valid/ready. A window that
// completes while the previous report is still unaccepted overwrites it and
// raises the sticky overrun flag, which clears once counting is disabled.
// CNT_W is limited to 32 bits by the shared saturating helper.
module sync_event_counter
  import sync_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int WINDOW    = 16,
  parameter int EDGE_MODE = 0
) (
  input  logic             clk_b,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_b,
  output logic [CNT_W-1:0] cnt_data,
  output logic             cnt_sat,
  output logic             cnt_valid,
  input  logic             cnt_ready,
  output logic             overrun
);

  localparam int               WIN_W    = win_cnt_w(WINDOW);
  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] ACC_MAX  = {CNT_W{1'b1}};

  state_t             state_r;
  state_t             state_nxt_s;
  logic [WIN_W-1:0]   win_cnt_r;
  logic [CNT_W-1:0]   acc_r;
  logic               sat_acc_r;
  logic               evt_s;
  logic [CNT_W-1:0]   acc_sum_s;
  logic               at_max_s;
  logic               win_end_s;
  logic               xfer_s;

  sync_edge_qual #(
    .EDGE_MODE (EDGE_MODE)
  ) u_edge_qual (
    .clk_b (clk_b),
    .rst_n (rst_n),
    .sig_b (sig_b),
    .evt   (evt_s)
  );

  // State register.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: en alone decides between idling and counting.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_nxt_s = ST_COUNT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_COUNT: begin
        if (!en) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_COUNT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Per-cycle datapath terms: saturating sum, saturation hit, window end, transfer.
  always_comb begin
    acc_sum_s = CNT_W'(sat_inc(32'(acc_r), 32'(ACC_MAX), evt_s));
    at_max_s  = evt_s & (acc_r == ACC_MAX);
    xfer_s    = cnt_valid & cnt_ready;
    if ((state_r == ST_COUNT) && (win_cnt_r == WIN_LAST)) begin
      win_end_s = 1'b1;
    end else begin
      win_end_s = 1'b0;
    end
  end

  // Window position and accumulator; idle holds them at zero so that the
  // first counting cycle always starts a fresh window.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt_r <= {WIN_W{1'b0}};
      acc_r     <= {CNT_W{1'b0}};
      sat_acc_r <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      win_cnt_r <= {WIN_W{1'b0}};
      acc_r     <= {CNT_W{1'b0}};
      sat_acc_r <= 1'b0;
    end else if (win_end_s) begin
      win_cnt_r <= {WIN_W{1'b0}};
      acc_r     <= {CNT_W{1'b0}};
      sat_acc_r <= 1'b0;
    end else begin
      win_cnt_r <= win_cnt_r + WIN_W'(1'b1);
      acc_r     <= acc_sum_s;
      sat_acc_r <= sat_acc_r | at_max_s;
    end
  end

  // Report register and handshake; a window end always wins over a transfer.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      cnt_data  <= {CNT_W{1'b0}};
      cnt_sat   <= 1'b0;
      cnt_valid <= 1'b0;
    end else if (win_end_s) begin
      cnt_data  <= acc_sum_s;
      cnt_sat   <= sat_acc_r | at_max_s;
      cnt_valid <= 1'b1;
    end else if (xfer_s) begin
      cnt_valid <= 1'b0;
    end else begin
      cnt_valid <= cnt_valid;
    end
  end

  // Sticky overrun: set when an unaccepted report is overwritten, cleared in idle.
  always_ff @(posedge clk_b or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (state_r == ST_IDLE) begin
      overrun <= 1'b0;
    end else if (win_end_s && cnt_valid && !cnt_ready) begin
      overrun <= 1'b1;
    end else begin
      overrun <= overrun;
    end
  end

endmodule

// File: tb/tb_sync_event_counter.sv
// Three instances share one clock and reset: 0 = defaults, 1 = CNT_W 4,
// 2 = EDGE_MODE 1. A window-level reference model (unbounded event count,
// clamped when the window closes) predicts every report.
module tb_sync_event_counter;

  localparam int WIN = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en_v[3];
  logic       sig_v[3];
  logic       rdy_v[3];
  logic [7:0] o_data0, o_data2;
  logic [3:0] o_data1;
  logic [7:0] o_data[3];
  logic       o_sat[3], o_valid[3], o_ovr[3];

  int errors = 0;
  int checks = 0;

  // reference model state
  bit m_act[3], m_prev[3], m_valid[3], m_sat[3], m_ovr[3];
  int m_pos[3], m_cnt[3], m_data[3];

  always #5 clk = ~clk;

  assign o_data[0] = o_data0;
  assign o_data[1] = {4'b0000, o_data1};
  assign o_data[2] = o_data2;

  sync_event_counter #(.CNT_W(8), .WINDOW(WIN), .EDGE_MODE(0)) u_dut0 (
    .clk_b(clk), .rst_n(rst_n), .en(en_v[0]), .sig_b(sig_v[0]),
    .cnt_data(o_data0), .cnt_sat(o_sat[0]), .cnt_valid(o_valid[0]),
    .cnt_ready(rdy_v[0]), .overrun(o_ovr[0]));

  sync_event_counter #(.CNT_W(4), .WINDOW(WIN), .EDGE_MODE(0)) u_dut1 (
    .clk_b(clk), .rst_n(rst_n), .en(en_v[1]), .sig_b(sig_v[1]),
    .cnt_data(o_data1), .cnt_sat(o_sat[1]), .cnt_valid(o_valid[1]),
    .cnt_ready(rdy_v[1]), .overrun(o_ovr[1]));

  sync_event_counter #(.CNT_W(8), .WINDOW(WIN), .EDGE_MODE(1)) u_dut2 (
    .clk_b(clk), .rst_n(rst_n), .en(en_v[2]), .sig_b(sig_v[2]),
    .cnt_data(o_data2), .cnt_sat(o_sat[2]), .cnt_valid(o_valid[2]),
    .cnt_ready(rdy_v[2]), .overrun(o_ovr[2]));

  function automatic int maxv(input int d);
    return (d == 1) ? 15 : 255;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_act[d] = 1'b0; m_prev[d] = 1'b0; m_valid[d] = 1'b0; m_sat[d] = 1'b0;
      m_ovr[d] = 1'b0; m_pos[d] = 0; m_cnt[d] = 0; m_data[d] = 0;
    end
  endtask

  // Effect of one rising edge on each instance, from the inputs held before it.
  task automatic model_step();
    for (int d = 0; d < 3; d++) begin
      bit e;
      e = (d == 2) ? (sig_v[d] & ~m_prev[d]) : sig_v[d];
      m_prev[d] = sig_v[d];
      if (m_act[d]) begin
        m_cnt[d] += int'(e);
        if (m_pos[d] == WIN - 1) begin
          if (m_valid[d] && !rdy_v[d]) m_ovr[d] = 1'b1;
          m_data[d]  = (m_cnt[d] > maxv(d)) ? maxv(d) : m_cnt[d];
          m_sat[d]   = (m_cnt[d] > maxv(d));
          m_valid[d] = 1'b1;
          m_cnt[d]   = 0;
          m_pos[d]   = 0;
        end else begin
          if (m_valid[d] && rdy_v[d]) m_valid[d] = 1'b0;
          m_pos[d]++;
        end
      end else begin
        m_ovr[d] = 1'b0;
        if (m_valid[d] && rdy_v[d]) m_valid[d] = 1'b0;
        m_cnt[d] = 0;
        m_pos[d] = 0;
      end
      m_act[d] = en_v[d];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
  endtask

  task automatic all_quiet();
    for (int d = 0; d < 3; d++) begin
      en_v[d] = 1'b0; sig_v[d] = 1'b0; rdy_v[d] = 1'b0;
    end
  endtask

  task automatic test_reset();
    all_quiet();
    rst_n = 1'b0;
    model_reset();
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (o_valid[d] !== 1'b0 || o_data[d] !== 8'd0 || o_sat[d] !== 1'b0 || o_ovr[d] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d got v=%b d=%0d s=%b o=%b exp all 0", d, o_valid[d], o_data[d], o_sat[d], o_ovr[d]);
      end
    end
    rst_n = 1'b1;
    tick(); tick();
  endtask

  task automatic test_basic();
    en_v[0] = 1'b1; rdy_v[0] = 1'b1; sig_v[0] = 1'b0;
    tick();
    for (int k = 0; k < WIN; k++) begin
      sig_v[0] = (k == 1 || k == 4 || k == 7 || k == 10 || k == 13);
      tick();
      checks++;
      if (o_valid[0] !== m_valid[0]) begin
        errors++;
        $display("FAIL basic_valid k=%0d got %b exp %b", k, o_valid[0], m_valid[0]);
      end
    end
    checks++;
    if (o_valid[0] !== 1'b1 || o_data[0] !== 8'd5 || o_sat[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_beat got v=%b d=%0d s=%b exp v=1 d=5 s=0", o_valid[0], o_data[0], o_sat[0]);
    end
    sig_v[0] = 1'b0;
    tick();
    checks++;
    if (o_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_drop got v=%b exp 0", o_valid[0]);
    end
    all_quiet(); tick(); tick();
  endtask

  task automatic test_saturation();
    en_v[1] = 1'b1; rdy_v[1] = 1'b1;
    tick();
    for (int k = 0; k < WIN; k++) begin
      sig_v[1] = 1'b1;
      tick();
    end
    checks++;
    if (o_valid[1] !== 1'b1 || o_data[1] !== 8'd15 || o_sat[1] !== 1'b1) begin
      errors++;
      $display("FAIL sat_full got v=%b d=%0d s=%b exp v=1 d=15 s=1", o_valid[1], o_data[1], o_sat[1]);
    end
    for (int k = 0; k < WIN; k++) begin
      sig_v[1] = (k == 3 || k == 9);
      tick();
    end
    checks++;
    if (o_valid[1] !== 1'b1 || o_data[1] !== 8'd2 || o_sat[1] !== 1'b0) begin
      errors++;
      $display("FAIL sat_next got v=%b d=%0d s=%b exp v=1 d=2 s=0", o_valid[1], o_data[1], o_sat[1]);
    end
    all_quiet(); tick(); tick();
  endtask

  task automatic test_overrun();
    en_v[0] = 1'b1; rdy_v[0] = 1'b0;
    tick();
    for (int k = 0; k < WIN; k++) begin
      sig_v[0] = (k < 3);
      tick();
    end
    checks++;
    if (o_valid[0] !== 1'b1 || o_data[0] !== 8'd3 || o_ovr[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovr_first got v=%b d=%0d o=%b exp v=1 d=3 o=0", o_valid[0], o_data[0], o_ovr[0]);
    end
    for (int k = 0; k < WIN; k++) begin
      sig_v[0] = ((k % 2) == 0) && (k < 14);
      tick();
    end
    checks++;
    if (o_valid[0] !== 1'b1 || o_data[0] !== 8'd7 || o_ovr[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_second got v=%b d=%0d o=%b exp v=1 d=7 o=1", o_valid[0], o_data[0], o_ovr[0]);
    end
    sig_v[0] = 1'b0; rdy_v[0] = 1'b1;
    tick();
    checks++;
    if (o_valid[0] !== 1'b0 || o_ovr[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_accept got v=%b o=%b exp v=0 o=1", o_valid[0], o_ovr[0]);
    end
    tick(); tick(); tick();
    checks++;
    if (o_ovr[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky got %b exp 1", o_ovr[0]);
    end
    en_v[0] = 1'b0;
    tick(); tick();
    checks++;
    if (o_ovr[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear got %b exp 0", o_ovr[0]);
    end
    all_quiet(); tick();
  endtask

  task automatic test_back_to_back();
    en_v[0] = 1'b1; rdy_v[0] = 1'b1;
    tick();
    for (int k = 0; k < 2 * WIN; k++) begin
      sig_v[0] = (k == WIN - 1 || k == WIN);
      tick();
      if (k == WIN - 1 || k == 2 * WIN - 1) begin
        checks++;
        if (o_valid[0] !== 1'b1 || o_data[0] !== 8'd1) begin
          errors++;
          $display("FAIL b2b_report k=%0d got v=%b d=%0d exp v=1 d=1", k, o_valid[0], o_data[0]);
        end
      end
    end
    // second pass: ready only when the pending report meets the next window end
    for (int k = 0; k < 2 * WIN; k++) begin
      sig_v[0] = (k == WIN - 1 || k == WIN);
      rdy_v[0] = (k == 0 || k == 2 * WIN - 1);
      tick();
    end
    checks++;
    if (o_valid[0] !== 1'b1 || o_data[0] !== 8'd1 || o_ovr[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_simul got v=%b d=%0d o=%b exp v=1 d=1 o=0", o_valid[0], o_data[0], o_ovr[0]);
    end
    en_v[0] = 1'b0; rdy_v[0] = 1'b0; sig_v[0] = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (o_valid[0] !== 1'b1 || o_data[0] !== 8'd1) begin
      errors++;
      $display("FAIL hold_pending got v=%b d=%0d exp v=1 d=1", o_valid[0], o_data[0]);
    end
    rdy_v[0] = 1'b1;
    tick();
    checks++;
    if (o_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got v=%b exp 0", o_valid[0]);
    end
    all_quiet(); tick();
  endtask

  task automatic test_reset_mid();
    int n;
    en_v[0] = 1'b1; rdy_v[0] = 1'b0;
    tick();
    for (int k = 0; k < 2 * WIN + 12; k++) begin
      sig_v[0] = (k >= 2 * WIN) ? (k < 2 * WIN + 9) : (k % 4 == 0);
      tick();
    end
    checks++;
    if (o_valid[0] !== 1'b1 || o_ovr[0] !== 1'b1 || m_cnt[0] != 9) begin
      errors++;
      $display("FAIL rstmid_pre got v=%b o=%b exp v=1 o=1", o_valid[0], o_ovr[0]);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (o_valid[d] !== 1'b0 || o_data[d] !== 8'd0 || o_sat[d] !== 1'b0 || o_ovr[d] !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_async dut%0d got v=%b d=%0d s=%b o=%b exp all 0", d, o_valid[d], o_data[d], o_sat[d], o_ovr[d]);
      end
    end
    all_quiet();
    tick();
    rst_n = 1'b1;
    tick(); tick();
    en_v[0] = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (o_valid[0] !== 1'b1 && n < 40);
    checks++;
    if (n != WIN + 1) begin
      errors++;
      $display("FAIL rstmid_latency got %0d cycles exp %0d", n, WIN + 1);
    end
    all_quiet(); rdy_v[0] = 1'b1; tick(); tick();
    all_quiet(); tick();
  endtask

  task automatic test_edge_mode();
    sig_v[2] = 1'b1; rdy_v[2] = 1'b1;
    tick(); tick();
    en_v[2] = 1'b1;
    tick();
    for (int k = 0; k < WIN; k++) begin
      sig_v[2] = (k < 6) || (k >= 8 && k < 12);
      tick();
    end
    checks++;
    if (o_valid[2] !== 1'b1 || o_data[2] !== 8'd1) begin
      errors++;
      $display("FAIL edge_preheld got v=%b d=%0d exp v=1 d=1", o_valid[2], o_data[2]);
    end
    for (int k = 0; k < WIN; k++) begin
      sig_v[2] = (k >= 2 && k < 8) || (k >= 10 && k < 14);
      tick();
    end
    checks++;
    if (o_valid[2] !== 1'b1 || o_data[2] !== 8'd2 || {24'd0, o_data[2]} !== m_data[2]) begin
      errors++;
      $display("FAIL edge_count got v=%b d=%0d exp v=1 d=2", o_valid[2], o_data[2]);
    end
    all_quiet(); tick(); tick();
  endtask

  task automatic test_random();
    for (int d = 0; d < 3; d++) en_v[d] = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int d = 0; d < 3; d++) begin
        if ($urandom_range(0, 99) == 0) en_v[d] = ~en_v[d];
        sig_v[d] = ($urandom_range(0, 3) != 0);
        rdy_v[d] = ($urandom_range(0, 1) != 0);
      end
      tick();
      for (int d = 0; d < 3; d++) begin
        checks += 4;
        if (o_valid[d] !== m_valid[d]) begin
          errors++;
          $display("FAIL rnd_valid c=%0d dut%0d got %b exp %b", c, d, o_valid[d], m_valid[d]);
        end
        if ({24'd0, o_data[d]} !== m_data[d]) begin
          errors++;
          $display("FAIL rnd_data c=%0d dut%0d got %0d exp %0d", c, d, o_data[d], m_data[d]);
        end
        if (o_sat[d] !== m_sat[d]) begin
          errors++;
          $display("FAIL rnd_sat c=%0d dut%0d got %b exp %b", c, d, o_sat[d], m_sat[d]);
        end
        if (o_ovr[d] !== m_ovr[d]) begin
          errors++;
          $display("FAIL rnd_overrun c=%0d dut%0d got %b exp %b", c, d, o_ovr[d], m_ovr[d]);
        end
      end
    end
    all_quiet(); tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    all_quiet();
    model_reset();
    test_reset();
    test_basic();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_edge_mode();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
